// File: rtl/demux_stream_pkg.sv
// Shared types and helpers for the 1-to-N stream demultiplexer.
package demux_stream_pkg;

    localparam int unsigned DROP_CNT_W = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

    typedef enum logic [1:0] {
        SEL_UNICAST,
        SEL_BCAST,
        SEL_DROP
    } sel_kind_e;

    // Decide what an accepted word does, given its select and the channel count.
    function automatic sel_kind_e classify(input int unsigned sel,
                                           input int unsigned n_out,
                                           input logic        bcast_en);
        if (sel < n_out) begin
            return SEL_UNICAST;
        end
        if (bcast_en && (sel == n_out)) begin
            return SEL_BCAST;
        end
        return SEL_DROP;
    endfunction

endpackage

// File: rtl/demux_sat_cnt.sv
// Saturating up-counter; sticks at all-ones.
module demux_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/demux_stream_n.sv
// Registered 1-to-N valid/ready stream demux with drop counter.
// Define DEMUX_STREAM_BCAST_EN to make in_sel_i == N_OUT broadcast to all channels.
module demux_stream_n
    import demux_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N_OUT = 4,
    parameter int unsigned SEL_W = $clog2(N_OUT + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [WIDTH-1:0]         in_data_i,
    input  logic [SEL_W-1:0]         in_sel_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic [N_OUT*WIDTH-1:0]   out_data_o,
    output logic [N_OUT-1:0]         out_valid_o,
    input  logic [N_OUT-1:0]         out_ready_i,
    output logic [DROP_CNT_W-1:0]    drop_cnt_o
);

`ifdef DEMUX_STREAM_BCAST_EN
    localparam logic BCAST_EN = 1'b1;
`else
    localparam logic BCAST_EN = 1'b0;
`endif

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [N_OUT-1:0] pending_q;
    logic [N_OUT-1:0] pending_d;
    sel_kind_e        kind;
    logic             retire;
    logic             accept;
    logic             drop_inc;

    // Retire is vacuously true when empty, so it doubles as the ready term.
    always_comb begin
        kind        = classify(32'(in_sel_i), N_OUT, BCAST_EN);
        retire      = ((pending_q & ~out_ready_i) == '0);
        in_ready_o  = retire;
        accept      = in_valid_i & retire;
        drop_inc    = 1'b0;
        data_d      = data_q;
        pending_d   = pending_q & ~out_ready_i;
        out_valid_o = pending_q;
        out_data_o  = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (pending_q[k]) begin
                out_data_o[k*WIDTH +: WIDTH] = data_q;
            end
        end
        if (accept) begin
            case (kind)
                SEL_UNICAST: begin
                    data_d    = in_data_i;
                    pending_d = N_OUT'(1) << in_sel_i;
                end
`ifdef DEMUX_STREAM_BCAST_EN
                SEL_BCAST: begin
                    data_d    = in_data_i;
                    pending_d = '1;
                end
`endif
                default: begin
                    drop_inc = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q    <= '0;
            pending_q <= '0;
        end else begin
            data_q    <= data_d;
            pending_q <= pending_d;
        end
    end

    demux_sat_cnt #(
        .W (DROP_CNT_W)
    ) u_drop_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (drop_inc),
        .count_o (drop_cnt_o)
    );

endmodule

// File: tb/tb_demux_stream_n.sv
// Directed self-checking bench for demux_stream_n (WIDTH=8, N_OUT=4).
// Follows DEMUX_STREAM_BCAST_EN to pick broadcast or drop expectations for sel=4.
module tb_demux_stream_n;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned N_OUT = 4;
    localparam int unsigned SEL_W = 3;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic [WIDTH-1:0]       in_data_i;
    logic [SEL_W-1:0]       in_sel_i;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [N_OUT*WIDTH-1:0] out_data_o;
    logic [N_OUT-1:0]       out_valid_o;
    logic [N_OUT-1:0]       out_ready_i;
    logic [7:0]             drop_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    demux_stream_n #(
        .WIDTH (WIDTH),
        .N_OUT (N_OUT),
        .SEL_W (SEL_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_data_i   (in_data_i),
        .in_sel_i    (in_sel_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .drop_cnt_o  (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic v, input logic [SEL_W-1:0] sel,
                         input logic [WIDTH-1:0] d, input logic [N_OUT-1:0] rdy);
        in_valid_i  = v;
        in_sel_i    = sel;
        in_data_i   = d;
        out_ready_i = rdy;
    endtask

    task automatic edge_step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic all_quiet;

        rst_i = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 4'hF);
        #12;
        chk("rst_valid", 32'(out_valid_o), 32'h0);
        chk("rst_data", out_data_o, 32'h0);
        chk("rst_drop", 32'(drop_cnt_o), 32'h0);
        edge_step();
        rst_i = 1'b0;
        #1;
        chk("rst_ready", 32'(in_ready_o), 32'h1);

        // Single word to ch2
        drive(1'b1, 3'd2, 8'hA5, 4'hF);
        #1;
        chk("t1_ready_pre", 32'(in_ready_o), 32'h1);
        edge_step();
        drive(1'b0, 3'd0, 8'h00, 4'hF);
        #1;
        chk("t1_valid", 32'(out_valid_o), 32'h4);
        chk("t1_data", out_data_o, 32'h00A5_0000);
        chk("t1_ready", 32'(in_ready_o), 32'h1);
        edge_step();
        chk("t1_valid_done", 32'(out_valid_o), 32'h0);

        // Back-to-back, no bubble
        drive(1'b1, 3'd0, 8'h11, 4'hF);
        edge_step();
        drive(1'b1, 3'd1, 8'h22, 4'hF);
        #1;
        chk("t2_v0", 32'(out_valid_o), 32'h1);
        chk("t2_d0", out_data_o, 32'h0000_0011);
        chk("t2_r0", 32'(in_ready_o), 32'h1);
        edge_step();
        drive(1'b1, 3'd0, 8'h33, 4'hF);
        #1;
        chk("t2_v1", 32'(out_valid_o), 32'h2);
        chk("t2_d1", out_data_o, 32'h0000_2200);
        edge_step();
        drive(1'b0, 3'd0, 8'h00, 4'hF);
        #1;
        chk("t2_v2", 32'(out_valid_o), 32'h1);
        chk("t2_d2", out_data_o, 32'h0000_0033);
        edge_step();
        chk("t2_idle", 32'(out_valid_o), 32'h0);

        // Stall ch3 for 5 cycles while a second word waits
        drive(1'b1, 3'd3, 8'h5A, 4'b0111);
        edge_step();
        drive(1'b1, 3'd0, 8'h77, 4'b0111);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_stall_valid", 32'(out_valid_o), 32'h8);
            chk("t3_stall_data", out_data_o, 32'h5A00_0000);
            chk("t3_stall_ready", 32'(in_ready_o), 32'h0);
            edge_step();
        end
        out_ready_i = 4'hF;
        #1;
        chk("t3_rel_ready", 32'(in_ready_o), 32'h1);
        chk("t3_rel_valid", 32'(out_valid_o), 32'h8);
        edge_step();
        drive(1'b0, 3'd0, 8'h00, 4'hF);
        #1;
        chk("t3_next_valid", 32'(out_valid_o), 32'h1);
        chk("t3_next_data", out_data_o, 32'h0000_0077);
        edge_step();
        chk("t3_idle", 32'(out_valid_o), 32'h0);

`ifdef DEMUX_STREAM_BCAST_EN
        // Broadcast with staggered channel readiness
        drive(1'b1, 3'd4, 8'hC3, 4'b0101);
        edge_step();
        drive(1'b1, 3'd1, 8'h9E, 4'b0101);
        #1;
        chk("bc_valid_all", 32'(out_valid_o), 32'hF);
        chk("bc_data_all", out_data_o, 32'hC3C3_C3C3);
        chk("bc_ready0", 32'(in_ready_o), 32'h0);
        edge_step();
        out_ready_i = 4'b0000;
        #1;
        chk("bc_valid_odd", 32'(out_valid_o), 32'hA);
        chk("bc_data_odd", out_data_o, 32'hC300_C300);
        chk("bc_ready1", 32'(in_ready_o), 32'h0);
        edge_step();
        out_ready_i = 4'b1010;
        #1;
        chk("bc_valid_last", 32'(out_valid_o), 32'hA);
        chk("bc_ready_last", 32'(in_ready_o), 32'h1);
        edge_step();
        drive(1'b0, 3'd0, 8'h00, 4'hF);
        #1;
        chk("bc_next_valid", 32'(out_valid_o), 32'h2);
        chk("bc_next_data", out_data_o, 32'h0000_9E00);
        edge_step();
        // sel above N_OUT is still dropped
        drive(1'b1, 3'd7, 8'hEE, 4'hF);
        edge_step();
        drive(1'b0, 3'd0, 8'h00, 4'hF);
        #1;
        chk("bc_drop7_valid", 32'(out_valid_o), 32'h0);
        chk("bc_drop7_cnt", 32'(drop_cnt_o), 32'd1);
`else
        // Out-of-range selects drop and saturate the counter
        drive(1'b1, 3'd4, 8'hEE, 4'hF);
        edge_step();
        #1;
        chk("drop_first_cnt", 32'(drop_cnt_o), 32'd1);
        chk("drop_first_valid", 32'(out_valid_o), 32'h0);
        all_quiet = 1'b1;
        for (int i = 1; i < 300; i++) begin
            in_sel_i  = (i % 2 == 1) ? 3'd7 : 3'd4;
            in_data_i = 8'(i);
            edge_step();
            if (out_valid_o != 4'h0 || in_ready_o != 1'b1) begin
                all_quiet = 1'b0;
            end
        end
        drive(1'b0, 3'd0, 8'h00, 4'hF);
        chk("drop_never_valid", 32'(all_quiet), 32'h1);
        chk("drop_saturated", 32'(drop_cnt_o), 32'd255);
        edge_step();
        chk("drop_hold", 32'(drop_cnt_o), 32'd255);
`endif

        // Async reset while ch1 is stalled
        drive(1'b1, 3'd1, 8'h66, 4'b0000);
        edge_step();
        drive(1'b0, 3'd0, 8'h00, 4'b0000);
        #1;
        chk("rs_held_valid", 32'(out_valid_o), 32'h2);
        rst_i = 1'b1;
        #1;
        chk("rs_valid_now", 32'(out_valid_o), 32'h0);
        chk("rs_data_now", out_data_o, 32'h0);
        chk("rs_drop_now", 32'(drop_cnt_o), 32'h0);
        edge_step();
        rst_i       = 1'b0;
        out_ready_i = 4'hF;
        #1;
        chk("rs_ready_after", 32'(in_ready_o), 32'h1);
        chk("rs_valid_after", 32'(out_valid_o), 32'h0);
        edge_step();
        chk("rs_no_resume", 32'(out_valid_o), 32'h0);
        chk("rs_no_data", out_data_o, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/demux_stream_n.md
# demux_stream_n

Registered, parametrised 1-to-N stream demultiplexer with valid/ready handshake on every port. It routes words (typically UART RX bytes) from a single producer to one of N_OUT consumers chosen per word by a select field. It replaces fixed 1-to-2 combinational demuxes in the UART peripheral path where consumers can stall. Optional broadcast delivers one word to all consumers. Out-of-range selects are dropped and counted.

## Interface
- WIDTH, 8: data word width in bits.
- N_OUT, 4: number of output channels, 2..16.
- SEL_W, $clog2(N_OUT+1): select width; always wide enough to encode N_OUT.
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- in_data_i  in  WIDTH  input word.
- in_sel_i  in  SEL_W  destination of input word, sampled with in_data_i.
- in_valid_i  in  1  input word present.
- in_ready_o  out  1  block accepts word this cycle.
- out_data_o  out  N_OUT x WIDTH  per-channel data.
- out_valid_o  out  N_OUT  per-channel valid.
- out_ready_i  in  N_OUT  per-channel ready.
- drop_cnt_o  out  8  saturating count of dropped words.

## Operation
- One holding register: data (WIDTH), pending mask (N_OUT bits). State FULL = (pending != 0); EMPTY otherwise.
- Accept = in_valid_i & in_ready_o.
- in_ready_o = EMPTY | retire. retire = every pending bit k has out_ready_i[k] this cycle. This is a combinational path from out_ready_i. No bubble on back-to-back traffic.
- On accept with in_sel_i < N_OUT: load data and set pending = one-hot(in_sel_i).
- On accept with in_sel_i == N_OUT and broadcast compiled in: load data and set pending = all ones.
- On accept with any other in_sel_i: word is discarded. drop_cnt_o increments, saturating at 255. Register clears if it retired that cycle, else holds.
- out_valid_o[k] = pending[k]. out_data_o[k] = held data when pending[k], else 0.
- Channel k handshake (pending[k] & out_ready_i[k]) clears pending[k] next edge. Channels in a broadcast complete independently, in any order.
- Retire and accept in the same cycle: new word loads, old pending cleared. No word is lost or duplicated.
- Words are delivered in acceptance order. A slow channel stalls all input (head-of-line blocking, by design).

## Timing
- Reset values: pending = 0, held data = 0, drop_cnt_o = 0. All out_valid_o = 0, all out_data_o = 0. in_ready_o = 1 once rst_i is low.
- Latency: word accepted at edge t is visible on out_valid_o/out_data_o after edge t, i.e. cycle t+1.
- Throughput: 1 word/cycle while the target channel holds out_ready_i high.
- out_valid_o[k] never drops without a handshake. out_data_o stays stable while valid.
- rst_i asserted mid-transfer: held word discarded immediately (async). No partial broadcast resumes after reset.
- in_valid_i low: register and counter unchanged except for output handshakes.

## Configuration
- DEMUX_STREAM_BCAST_EN defined: in_sel_i == N_OUT broadcasts to all channels. in_sel_i > N_OUT is dropped.
- Not defined: any in_sel_i >= N_OUT, including N_OUT, is dropped and counted. No broadcast logic is synthesised.

## Structure
- Package demux_stream_pkg holds:
  - DROP_CNT_W = 8.
  - DROP_CNT_MAX.
  - sel_kind_e enumeration (SEL_UNICAST, SEL_BCAST, SEL_DROP) returned by a classify function.
- Sub-module demux_sat_cnt: saturating counter (width parameter, inc_i, count_o), instantiated for drop_cnt_o.
- Everything else lives in one always_ff (register, pending mask) plus one always_comb (ready, retire, outputs).

## Test plan
- Reset then in_sel_i=2, data 0xA5, all ready=1 -> cycle after accept, out_valid_o = 4'b0100 and out_data_o[2] = 0xA5; other data 0; in_ready_o stays 1.
- Back-to-back 0x11 to ch0, 0x22 to ch1, 0x33 to ch0, ready=1 -> outputs on consecutive cycles in order, no bubble.
- 0x5A to ch3 with out_ready_i[3]=0 for 5 cycles -> valid and data stable, in_ready_o=0; release -> single delivery, in_ready_o=1 same cycle.
- With BCAST_EN: sel=4, data 0xC3; ready pattern ch0,ch2 first, ch1,ch3 two cycles later -> each channel sees exactly one valid beat of 0xC3; next word accepted on the cycle the last channel handshakes.
- Without BCAST_EN: sel=4 and sel=7, 300 times -> no out_valid_o; drop_cnt_o = 255 (saturated).
- rst_i pulsed while ch1 holds word under stall -> out_valid_o = 0 immediately, drop_cnt_o = 0. Held word never delivered after release.
